// File: rtl/sync_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo_if : producer/consumer handshake bundle for sync_fifo.           |
// | FIFO_COUNT_EN adds the count_o occupancy signal.                           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface sync_fifo_if #(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4
);
  logic             wr_en_i;
  logic [WIDTH-1:0] wdata_i;
  logic             full_o;
  logic             wr_error_o;
  logic             rd_en_i;
  logic [WIDTH-1:0] rdata_o;
  logic             empty_o;
  logic             rd_error_o;
`ifdef FIFO_COUNT_EN
  logic [PTR_WIDTH:0] count_o;

  modport slave (
    input  wr_en_i, wdata_i, rd_en_i,
    output full_o, wr_error_o, rdata_o, empty_o, rd_error_o, count_o
  );
  modport master (
    output wr_en_i, wdata_i, rd_en_i,
    input  full_o, wr_error_o, rdata_o, empty_o, rd_error_o, count_o
  );
`else
  modport slave (
    input  wr_en_i, wdata_i, rd_en_i,
    output full_o, wr_error_o, rdata_o, empty_o, rd_error_o
  );
  modport master (
    output wr_en_i, wdata_i, rd_en_i,
    input  full_o, wr_error_o, rdata_o, empty_o, rd_error_o
  );
`endif
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with registered read data and error pulses.  |
// | Optional macro FIFO_COUNT_EN exposes occupancy on count_o.                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sync_fifo #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  sync_fifo_if.slave bus
);

  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               wr_error_q, wr_error_d;
  logic               rd_error_q, rd_error_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic empty;
  logic full;
  logic wr_accept;
  logic rd_accept;

  // MSB is the wrap toggle: equal lower bits with differing toggles means full
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                 (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);

  always_comb begin
    wr_accept  = bus.wr_en_i && !full;
    rd_accept  = bus.rd_en_i && !empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rdata_d    = rdata_q;
    wr_error_d = bus.wr_en_i && full;
    rd_error_d = bus.rd_en_i && empty;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rdata_d  = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rdata_q    <= '0;
      wr_error_q <= 1'b0;
      rd_error_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rdata_q    <= rdata_d;
      wr_error_q <= wr_error_d;
      rd_error_q <= rd_error_d;
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= bus.wdata_i;
    end
  end

  assign bus.full_o     = full;
  assign bus.empty_o    = empty;
  assign bus.rdata_o    = rdata_q;
  assign bus.wr_error_o = wr_error_q;
  assign bus.rd_error_o = rd_error_q;

`ifdef FIFO_COUNT_EN
  assign bus.count_o = wr_ptr_q - rd_ptr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sync_fifo : randomized self-checking bench for sync_fifo against a      |
// | queue-based model. Define FIFO_COUNT_EN to also check count_o.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sync_fifo;

  localparam int DEPTH     = 16;
  localparam int WIDTH     = 8;
  localparam int PTR_WIDTH = 4;

  logic clk;
  logic rst_n;

  sync_fifo_if #(.WIDTH(WIDTH), .PTR_WIDTH(PTR_WIDTH)) bus ();

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_WIDTH(PTR_WIDTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Reference model: a plain queue plus the last word handed out
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_rdata;
  logic             m_wr_err;
  logic             m_rd_err;

  // One clock cycle of stimulus; model judges both requests on pre-edge occupancy
  task automatic apply(input logic wr, input logic [WIDTH-1:0] wd, input logic rd);
    bit wr_ok;
    bit rd_ok;
    bus.wr_en_i = wr;
    bus.wdata_i = wd;
    bus.rd_en_i = rd;
    wr_ok = wr && (q.size() < DEPTH);
    rd_ok = rd && (q.size() > 0);
    @(posedge clk);
    #1;
    if (rd_ok) m_rdata = q.pop_front();
    if (wr_ok) q.push_back(wd);
    m_wr_err = wr && !wr_ok;
    m_rd_err = rd && !rd_ok;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.wdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    m_rdata = '0;
    n_cmp++;
    if (bus.empty_o !== 1'b1 || bus.full_o !== 1'b0 || bus.rdata_o !== 8'h00 ||
        bus.wr_error_o !== 1'b0 || bus.rd_error_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset: empty=%b full=%b rdata=%h wr_err=%b rd_err=%b, required 1 0 00 0 0",
               bus.empty_o, bus.full_o, bus.rdata_o, bus.wr_error_o, bus.rd_error_o);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b1, 8'(i), 1'b0);
      n_cmp++;
      if (bus.full_o !== (i == DEPTH - 1)) begin
        n_err++;
        $display("FAIL fill_full[%0d]: full=%b required %b", i, bus.full_o, (i == DEPTH - 1));
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (bus.rdata_o !== 8'(i) || bus.empty_o !== (i == DEPTH - 1)) begin
        n_err++;
        $display("FAIL drain[%0d]: rdata=%h empty=%b required %h %b",
                 i, bus.rdata_o, bus.empty_o, 8'(i), (i == DEPTH - 1));
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) apply(1'b1, 8'($urandom_range(0, 8'hA9)), 1'b0);
    apply(1'b1, 8'hAA, 1'b0);
    n_cmp++;
    if (bus.wr_error_o !== 1'b1 || bus.full_o !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_pulse: wr_err=%b full=%b required 1 1", bus.wr_error_o, bus.full_o);
    end
    apply(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (bus.wr_error_o !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_clear: wr_err=%b required 0", bus.wr_error_o);
    end
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (bus.rdata_o !== m_rdata || bus.rdata_o === 8'hAA) begin
        n_err++;
        $display("FAIL overflow_drain[%0d]: rdata=%h required %h (never AA)", i, bus.rdata_o, m_rdata);
      end
    end
  endtask

  task automatic test_underflow();
    logic [WIDTH-1:0] held;
    held = m_rdata;
    apply(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (bus.rd_error_o !== 1'b1 || bus.rdata_o !== held || bus.empty_o !== 1'b1) begin
      n_err++;
      $display("FAIL underflow_pulse: rd_err=%b rdata=%h empty=%b required 1 %h 1",
               bus.rd_error_o, bus.rdata_o, bus.empty_o, held);
    end
    apply(1'b0, 8'h00, 1'b0);
    n_cmp++;
    if (bus.rd_error_o !== 1'b0 || bus.rdata_o !== held) begin
      n_err++;
      $display("FAIL underflow_clear: rd_err=%b rdata=%h required 0 %h", bus.rd_error_o, bus.rdata_o, held);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) apply(1'b1, 8'(8'h50 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 8'(8'h55 + i), 1'b1);
      n_cmp++;
      if (bus.rdata_o !== 8'(8'h50 + i) || bus.empty_o !== 1'b0 || bus.full_o !== 1'b0 ||
          bus.wr_error_o !== 1'b0 || bus.rd_error_o !== 1'b0 || q.size() != 5) begin
        n_err++;
        $display("FAIL simul[%0d]: rdata=%h empty=%b full=%b wr_err=%b rd_err=%b required %h 0 0 0 0",
                 i, bus.rdata_o, bus.empty_o, bus.full_o, bus.wr_error_o, bus.rd_error_o, 8'(8'h50 + i));
      end
    end
    for (int i = 0; i < 5; i++) apply(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (bus.rdata_o !== 8'h68 || bus.empty_o !== 1'b1) begin
      n_err++;
      $display("FAIL simul_drain: rdata=%h empty=%b required 68 1", bus.rdata_o, bus.empty_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      // Bias toward writes for the first half and reads afterwards to hit both flags
      logic wr;
      logic rd;
      wr = ($urandom_range(0, 99) < ((i < 200) ? 70 : 30));
      rd = ($urandom_range(0, 99) < ((i < 200) ? 30 : 70));
      apply(wr, 8'($urandom), rd);
      n_cmp++;
      if (bus.rdata_o !== m_rdata || bus.empty_o !== (q.size() == 0) ||
          bus.full_o !== (q.size() == DEPTH) ||
          bus.wr_error_o !== m_wr_err || bus.rd_error_o !== m_rd_err) begin
        n_err++;
        $display("FAIL random[%0d]: rdata=%h empty=%b full=%b wr_err=%b rd_err=%b required %h %b %b %b %b",
                 i, bus.rdata_o, bus.empty_o, bus.full_o, bus.wr_error_o, bus.rd_error_o,
                 m_rdata, (q.size() == 0), (q.size() == DEPTH), m_wr_err, m_rd_err);
      end
`ifdef FIFO_COUNT_EN
      n_cmp++;
      if (bus.count_o !== (PTR_WIDTH+1)'(q.size())) begin
        n_err++;
        $display("FAIL random_count[%0d]: count=%0d required %0d", i, bus.count_o, q.size());
      end
`endif
    end
  endtask

  task automatic test_mid_reset();
    while (q.size() > 0) apply(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) apply(1'b1, 8'($urandom), 1'b0);
    n_cmp++;
    if (bus.empty_o !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_pre: empty=%b required 0", bus.empty_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_rdata = '0;
    n_cmp++;
    if (bus.empty_o !== 1'b1 || bus.full_o !== 1'b0 || bus.rdata_o !== 8'h00) begin
      n_err++;
      $display("FAIL midrst_async: empty=%b full=%b rdata=%h required 1 0 00",
               bus.empty_o, bus.full_o, bus.rdata_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(1'b1, 8'h3C, 1'b0);
`ifdef FIFO_COUNT_EN
    n_cmp++;
    if (bus.count_o !== 5'd1) begin
      n_err++;
      $display("FAIL midrst_count: count=%0d required 1", bus.count_o);
    end
`endif
    apply(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (bus.rdata_o !== 8'h3C || bus.empty_o !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_read: rdata=%h empty=%b required 3c 1", bus.rdata_o, bus.empty_o);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    m_rdata  = '0;
    m_wr_err = 1'b0;
    m_rd_err = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock first-in/first-out buffer, WIDTH bits wide and DEPTH entries deep.
- Registered read data, full/empty status flags, and one-cycle error pulses on illegal accesses.
- Sits between a producer and a consumer in the same clock domain.
- Replaces the dual-clock variant where both sides share one clock.

Parameters:
- DEPTH, 16, number of storage entries; must equal 2**PTR_WIDTH.
- WIDTH, 8, data word width in bits.
- PTR_WIDTH, 4, address width of the storage array.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- wr_en_i  input  1  write request.
- wdata_i  input  WIDTH  write data, sampled when a write is accepted.
- full_o  output  1  FIFO holds DEPTH entries.
- wr_error_o  output  1  one-cycle pulse: write requested while full.
- rd_en_i  input  1  read request.
- rdata_o  output  WIDTH  read data, registered.
- empty_o  output  1  FIFO holds zero entries.
- rd_error_o  output  1  one-cycle pulse: read requested while empty.

Behaviour:
- Pointers: wr_ptr and rd_ptr are PTR_WIDTH+1 bits wide; the MSB is a wrap toggle and the lower PTR_WIDTH bits address storage.
- Flags are combinational from the pointers:
  - empty_o = (wr_ptr == rd_ptr).
  - full_o = (MSBs differ AND lower bits equal).
- Reset (rst_ni low, asynchronous assert; release takes effect at the next clk_i edge):
  - Pointers = 0, rdata_o = 0, wr_error_o = 0, rd_error_o = 0.
  - Therefore empty_o = 1 and full_o = 0.
  - Storage contents are not cleared.
- Write accept: wr_en_i=1 and full_o=0 at the clock edge. Store wdata_i at wr_ptr[PTR_WIDTH-1:0]; wr_ptr increments by 1, wrapping modulo 2**(PTR_WIDTH+1).
- Write reject: wr_en_i=1 and full_o=1. No storage or pointer change; wr_error_o=1 for the next cycle only.
- Read accept: rd_en_i=1 and empty_o=0. rdata_o <= mem[rd_ptr[PTR_WIDTH-1:0]], valid the cycle after the request (1-cycle latency); rd_ptr increments.
- Read reject: rd_en_i=1 and empty_o=1. rdata_o holds its value; rd_error_o=1 for the next cycle only.
- rdata_o holds its last value whenever no read is accepted.
- Error outputs return to 0 on any cycle without a rejected request.
- Simultaneous read and write:
  - Both are judged against the flags present before the edge.
  - When not full and not empty: both proceed; occupancy is unchanged.
  - When full: the read proceeds; the write is rejected with wr_error_o.
  - When empty: the write proceeds; the read is rejected with rd_error_o, and the written data is not bypassed.
- Wrap-around: pointers roll over seamlessly. Storage index wraps after DEPTH-1; the toggle bit distinguishes full from empty.
- Reset mid-operation discards all pending entries immediately. Flags reflect empty asynchronously.

Optional Feature:
- Macro FIFO_COUNT_EN.
- When defined: adds output port count_o (PTR_WIDTH+1 bits) = wr_ptr - rd_ptr modulo 2**(PTR_WIDTH+1).
  - Ranges 0..DEPTH; reset value 0.
  - Updates in the same cycle as the pointers.
- When undefined: no count_o port and no subtractor logic; all other behaviour is identical.

Test Plan:
- Reset then idle: hold rst_ni=0 for 3 clocks, release -> empty_o=1, full_o=0, rdata_o=0, both errors 0.
- Fill then drain: write 0x00..0x0F (16 writes) -> full_o=1 after the 16th. Then 16 reads -> rdata_o = 0x00..0x0F in order, one cycle after each rd_en_i; empty_o=1 after the last.
- Overflow: with full, assert wr_en_i with 0xAA -> wr_error_o=1 for one cycle; subsequent reads never return 0xAA.
- Underflow: with empty, assert rd_en_i -> rd_error_o=1 for one cycle; rdata_o unchanged.
- Simultaneous access with 5 entries: assert both for 20 cycles with incrementing data -> occupancy stays 5, no errors, pointers wrap past index 15 with data order preserved.
- Mid-operation reset: 8 entries stored, pull rst_ni low between edges -> empty_o=1 immediately. After release, a write of 0x3C then a read returns 0x3C (count_o=1 between them when FIFO_COUNT_EN is defined).
